uart_tx_framed: RTL and testbench

UART_TX_FRAMED -- requirements
Module: uart_tx_framed

---
 rtl/uart_tx_framed.sv | 134 +++++++++++++
 tb/tb_uart_tx_framed.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_framed.sv
// UART transmitter with an AXI-Stream style input, configurable framing and
// optional CTS flow control. One frame in flight; the line idles high.
module uart_tx_framed #(
  parameter real CLK_FREQ  = 100e6,
  parameter real BAUD_RATE = 9600,
  parameter int  DATA_BITS = 8,
  parameter int  PARITY    = 0,
  parameter int  STOP_BITS = 1,
  parameter int  USE_CTS   = 0
) (
  input  logic                 clk,
  input  logic                 sresetn,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic [DATA_BITS-1:0] s_axis_tdata,
  input  logic                 cts_n,
  output logic                 serial_data,
  output logic                 busy
);

  localparam int CLKS_PER_BIT = $rtoi(CLK_FREQ / BAUD_RATE);
  localparam int FRAME_BITS   = 1 + DATA_BITS + ((PARITY != 0) ? 1 : 0) + STOP_BITS;
  localparam int BAUD_W       = $clog2(CLKS_PER_BIT);
  localparam int BIT_W        = $clog2(FRAME_BITS + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  LAST_DATA = BIT_W'(DATA_BITS);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(FRAME_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $fatal(1, "uart_tx_framed: CLK_FREQ/BAUD_RATE must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $fatal(1, "uart_tx_framed: DATA_BITS must be in 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $fatal(1, "uart_tx_framed: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $fatal(1, "uart_tx_framed: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  state_t               r_state;
  logic [BAUD_W-1:0]    r_baud_cnt;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_parity;
  logic                 r_serial;
  logic                 r_busy;
  logic [1:0]           r_cts_sync;

  logic w_cts_ok;
  logic w_accept;
  logic w_bit_end;

  assign w_cts_ok      = (USE_CTS == 0) || !r_cts_sync[1];
  assign s_axis_tready = (r_state == S_IDLE) && w_cts_ok;
  assign w_accept      = s_axis_tvalid && s_axis_tready;
  assign w_bit_end     = (r_baud_cnt == BAUD_LAST);
  // Reset forces the line idle without waiting for a clock edge.
  assign serial_data   = r_serial | ~sresetn;
  assign busy          = r_busy;

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values and the block order cannot change behaviour.
  always_ff @(posedge clk) begin
    if (!sresetn) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_serial   <= 1'b1;
      r_busy     <= 1'b0;
      r_cts_sync <= 2'b11;
    end else begin
      r_cts_sync <= {r_cts_sync[0], cts_n};
      if (r_state == S_IDLE) begin
        r_baud_cnt <= '0;
        r_bit_cnt  <= '0;
        r_serial   <= 1'b1;
        if (w_accept) begin
          r_state  <= S_START;
          r_shift  <= s_axis_tdata;
          r_parity <= (^s_axis_tdata) ^ (PARITY == 1);
          r_serial <= 1'b0;
          r_busy   <= 1'b1;
        end
      end else if (!w_bit_end) begin
        r_baud_cnt <= r_baud_cnt + 1'b1;
      end else begin
        // Bit boundary: r_bit_cnt is the frame index of the bit just finished.
        r_baud_cnt <= '0;
        r_bit_cnt  <= r_bit_cnt + 1'b1;
        case (r_state)
          S_START: begin
            r_state  <= S_DATA;
            r_serial <= r_shift[0];
            r_shift  <= r_shift >> 1;
          end
          S_DATA: begin
            if (r_bit_cnt == LAST_DATA) begin
              if (PARITY != 0) begin
                r_state  <= S_PAR;
                r_serial <= r_parity;
              end else begin
                r_state  <= S_STOP;
                r_serial <= 1'b1;
              end
            end else begin
              r_serial <= r_shift[0];
              r_shift  <= r_shift >> 1;
            end
          end
          S_PAR: begin
            r_state  <= S_STOP;
            r_serial <= 1'b1;
          end
          S_STOP: begin
            if (r_bit_cnt == LAST_BIT) begin
              r_state   <= S_IDLE;
              r_busy    <= 1'b0;
              r_bit_cnt <= '0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_framed.sv
// Self-checking bench for uart_tx_framed: four configurations at 8 clocks/bit,
// accepted words go to a scoreboard and are compared cycle-by-cycle on the line.
module tb_uart_tx_framed;

  typedef struct {
    int         k;
    logic [8:0] d;
    int         acc;
  } exp_t;

  logic       clk;
  logic       rstn   [4];
  logic       tvalid [4];
  logic       tready [4];
  logic [8:0] tdata  [4];
  logic       cts_n  [4];
  logic       line   [4];
  logic       busy   [4];

  int   db_c  [4] = '{8, 8, 8, 5};
  int   par_c [4] = '{0, 2, 1, 0};
  int   ns_c  [4] = '{1, 1, 1, 2};

  exp_t sb[$];
  int   cyc = 0;
  int   acc_cnt [4] = '{0, 0, 0, 0};
  int   n_checks = 0;
  int   n_fail = 0;

  uart_tx_framed #(.CLK_FREQ(8e6), .BAUD_RATE(1e6), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .USE_CTS(0)) u_plain (
    .clk(clk), .sresetn(rstn[0]), .s_axis_tvalid(tvalid[0]), .s_axis_tready(tready[0]),
    .s_axis_tdata(tdata[0][7:0]), .cts_n(cts_n[0]), .serial_data(line[0]), .busy(busy[0]));

  uart_tx_framed #(.CLK_FREQ(8e6), .BAUD_RATE(1e6), .DATA_BITS(8), .PARITY(2),
                   .STOP_BITS(1), .USE_CTS(0)) u_even (
    .clk(clk), .sresetn(rstn[1]), .s_axis_tvalid(tvalid[1]), .s_axis_tready(tready[1]),
    .s_axis_tdata(tdata[1][7:0]), .cts_n(cts_n[1]), .serial_data(line[1]), .busy(busy[1]));

  uart_tx_framed #(.CLK_FREQ(8e6), .BAUD_RATE(1e6), .DATA_BITS(8), .PARITY(1),
                   .STOP_BITS(1), .USE_CTS(0)) u_odd (
    .clk(clk), .sresetn(rstn[2]), .s_axis_tvalid(tvalid[2]), .s_axis_tready(tready[2]),
    .s_axis_tdata(tdata[2][7:0]), .cts_n(cts_n[2]), .serial_data(line[2]), .busy(busy[2]));

  uart_tx_framed #(.CLK_FREQ(8e6), .BAUD_RATE(1e6), .DATA_BITS(5), .PARITY(0),
                   .STOP_BITS(2), .USE_CTS(1)) u_cts (
    .clk(clk), .sresetn(rstn[3]), .s_axis_tvalid(tvalid[3]), .s_axis_tready(tready[3]),
    .s_axis_tdata(tdata[3][4:0]), .cts_n(cts_n[3]), .serial_data(line[3]), .busy(busy[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Record every accepted word with the cycle it was accepted on.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 4; k++) begin
      if (rstn[k] && tvalid[k] && tready[k]) begin
        sb.push_back('{k, tdata[k], cyc});
        acc_cnt[k] <= acc_cnt[k] + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Waits for a start bit on instance k, then checks every cycle of the frame
  // against the frame built from the oldest scoreboard entry.
  task automatic rx_frame(input int k, output int t0);
    exp_t        e;
    logic [15:0] fr;
    logic [7:0]  smp;
    logic        p;
    bit          got;
    int          nb;
    int          bcnt;
    t0  = -1;
    got = 0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (line[k] == 1'b0) got = 1;
    end
    check($sformatf("rx_start_inst%0d", k), got, 1);
    if (!got) return;
    t0 = cyc;
    check($sformatf("rx_sb_avail_inst%0d", k), sb.size() != 0, 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check("rx_sb_inst", e.k, k);
    check($sformatf("rx_latency_inst%0d", k), t0 - e.acc, 1);

    nb = 1 + db_c[k] + ((par_c[k] != 0) ? 1 : 0) + ns_c[k];
    fr = '1;
    fr[0] = 1'b0;
    p = 1'b0;
    for (int j = 0; j < db_c[k]; j++) begin
      fr[1 + j] = e.d[j];
      p ^= e.d[j];
    end
    if (par_c[k] != 0) fr[1 + db_c[k]] = (par_c[k] == 1) ? ~p : p;

    bcnt = 0;
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < 8; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        smp[c] = line[k];
        bcnt += int'(busy[k]);
      end
      check($sformatf("inst%0d_data%0h_bit%0d", k, e.d, b), smp, {8{fr[b]}});
    end
    check($sformatf("inst%0d_busy_cycles", k), bcnt, nb * 8);
  endtask

  task automatic send_one(input int k, input logic [8:0] d, input bit scramble);
    int t0;
    @(negedge clk);
    tvalid[k] = 1'b1;
    tdata[k]  = d;
    fork
      rx_frame(k, t0);
      begin
        @(negedge clk);
        tvalid[k] = 1'b0;
        if (scramble) begin
          repeat (90) begin
            tdata[k] = 9'($urandom);
            @(negedge clk);
          end
        end
      end
    join
    @(negedge clk);
    check($sformatf("inst%0d_idle_line", k), line[k], 1);
    check($sformatf("inst%0d_idle_busy", k), busy[k], 0);
  endtask

  initial begin
    int t0;
    int t1;
    int cnt;
    exp_t e;

    for (int k = 0; k < 4; k++) begin
      rstn[k]   = 1'b0;
      tvalid[k] = 1'b0;
      tdata[k]  = '0;
      cts_n[k]  = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("reset_line_inst%0d", k), line[k], 1);
      check($sformatf("reset_busy_inst%0d", k), busy[k], 0);
    end
    for (int k = 0; k < 4; k++) rstn[k] = 1'b1;
    @(negedge clk);
    check("release_tready_plain", tready[0], 1);
    check("release_tready_cts_high", tready[3], 0);

    // Basic frames, parity variants, and tdata churn while a frame is in flight.
    send_one(0, 9'h0A5, 1'b0);
    send_one(0, 9'h03C, 1'b1);
    send_one(1, 9'h007, 1'b0);
    send_one(2, 9'h007, 1'b0);
    send_one(1, 9'h0B2, 1'b0);
    send_one(2, 9'h0FF, 1'b0);

    // Flow control and back-to-back framing on the 5-bit, 2-stop instance.
    tdata[3]  = 9'h01F;
    tvalid[3] = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      cnt += int'(tready[3]) + int'(!line[3]);
    end
    check("cts_blocked", cnt, 0);
    check("cts_blocked_acc", acc_cnt[3], 0);
    cts_n[3] = 1'b0;
    @(negedge clk);
    check("cts_sync_stage1", tready[3], 0);
    @(negedge clk);
    check("cts_sync_stage2", tready[3], 1);
    fork
      begin
        rx_frame(3, t0);
        rx_frame(3, t1);
      end
      begin
        for (int i = 0; i < 200 && acc_cnt[3] < 1; i++) @(negedge clk);
        check("b2b_first_accept", acc_cnt[3] >= 1, 1);
        tdata[3] = 9'h000;
        for (int i = 0; i < 200 && acc_cnt[3] < 2; i++) @(negedge clk);
        check("b2b_second_accept", acc_cnt[3] >= 2, 1);
        repeat (10) @(negedge clk);
        cts_n[3] = 1'b1;
      end
    join
    check("b2b_start_period", t1 - t0, 65);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cnt += int'(tready[3]) + int'(!line[3]);
    end
    check("cts_high_blocks_next", cnt, 0);
    check("cts_accept_total", acc_cnt[3], 2);
    tvalid[3] = 1'b0;

    // Reset in the middle of data bit 3 of an all-zero word.
    @(negedge clk);
    tvalid[0] = 1'b1;
    tdata[0]  = 9'h000;
    @(negedge clk);
    tvalid[0] = 1'b0;
    repeat (34) @(negedge clk);
    check("pre_reset_data_bit3", line[0], 0);
    rstn[0] = 1'b0;
    #1;
    check("reset_line_immediate", line[0], 1);
    check("reset_sb_pending", sb.size(), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("reset_sb_inst", e.k, 0);
    end
    repeat (2) @(negedge clk);
    rstn[0] = 1'b1;
    @(negedge clk);
    check("post_reset_tready", tready[0], 1);
    check("post_reset_busy", busy[0], 0);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cnt += int'(!line[0]) + int'(busy[0]);
    end
    check("post_reset_quiet", cnt, 0);
    check("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
